// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//   Serial-in/parallel-out front end. Serial bits accepted on ser_valid are
//   collected into WIDTH-bit words; each completed word is presented through a
//   one-entry valid/ready output register feeding the parallel register stage.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: first received bit lands in out_data[WIDTH-1]
//              0: first received bit lands in out_data[0]
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   ser_in     serial data bit, sampled only when ser_valid=1
//   ser_valid  qualifies ser_in
//   align      discards the partial word; next accepted bit is bit 0 of a word
//   out_data   completed word, valid while out_valid=1
//   out_valid  output register holds an unconsumed word
//   out_ready  consumer accepts the word when out_valid & out_ready
//   bit_count  bits collected in the current partial word (0..WIDTH-1)
//   overrun    sticky flag: a completed word was dropped (cleared by reset only)
// -----------------------------------------------------------------------------
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             align,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sh_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic             overrun_r;

  logic [WIDTH-1:0] base_s;
  logic [WIDTH-1:0] shifted_s;
  logic             complete_s;
  logic             load_s;
  logic             drop_s;

  // Shift datapath and word-completion / output-load decisions.
  always_comb begin
    base_s     = sh_r;
    shifted_s  = sh_r;
    complete_s = 1'b0;
    load_s     = 1'b0;
    drop_s     = 1'b0;

    // align throws away the partial word before the current bit is merged,
    // so a bit arriving with align becomes bit 0 of a fresh word.
    if (align) begin
      base_s = '0;
    end else begin
      base_s = sh_r;
    end

    if (MSB_FIRST) begin
      shifted_s = {base_s[WIDTH-2:0], ser_in};
    end else begin
      shifted_s = {ser_in, base_s[WIDTH-1:1]};
    end

    // shifted_s already contains the current bit, so it is the full candidate.
    complete_s = ser_valid & ~align & (cnt_r == CNT_MAX);
    load_s     = complete_s & (~out_valid_r | out_ready);
    drop_s     = complete_s & out_valid_r & ~out_ready;
  end

  // Shift register: moves only on accepted bits, cleared by align.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_r <= '0;
    end else if (ser_valid) begin
      sh_r <= shifted_s;
    end else if (align) begin
      sh_r <= '0;
    end else begin
      sh_r <= sh_r;
    end
  end

  // Bit counter: wraps on word completion, restarts on align.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (align) begin
      cnt_r <= ser_valid ? CNT_ONE : '0;
    end else if (ser_valid) begin
      cnt_r <= (cnt_r == CNT_MAX) ? '0 : (cnt_r + CNT_ONE);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Output holding register: a completion consumed in the same cycle as a
  // handshake replaces the held word and keeps out_valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_data_r  <= shifted_s;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
    end else begin
      out_data_r  <= out_data_r;
      out_valid_r <= out_valid_r;
    end
  end

  // Sticky overrun flag: set when a completed word finds the register full.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign bit_count = cnt_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
//   Drives an MSB-first and an LSB-first deserializer (WIDTH=8) with the same
//   stimulus and compares every cycle against a queue-based word model, plus
//   directed scenarios with fixed expected words.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

  localparam int W = 8;

  logic       clk;
  logic       reset;
  logic       ser_in;
  logic       ser_valid;
  logic       align;
  logic       out_ready;

  logic [7:0] m_data;
  logic       m_valid;
  logic [2:0] m_count;
  logic       m_overrun;
  logic [7:0] l_data;
  logic       l_valid;
  logic [2:0] l_count;
  logic       l_overrun;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic       bits_q[$];
  logic [7:0] md_m;
  logic [7:0] md_l;
  logic       mv;
  logic       mov;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
    .align(align), .out_data(m_data), .out_valid(m_valid),
    .out_ready(out_ready), .bit_count(m_count), .overrun(m_overrun)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
    .align(align), .out_data(l_data), .out_valid(l_valid),
    .out_ready(out_ready), .bit_count(l_count), .overrun(l_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: a word is the list of accepted bits; it completes when
  // the list reaches W entries and is then placed into the output slot.
  task automatic model_update();
    logic hs;
    logic [7:0] wm;
    logic [7:0] wl;
    if (reset) begin
      bits_q.delete();
      md_m = 8'h00;
      md_l = 8'h00;
      mv   = 1'b0;
      mov  = 1'b0;
    end else begin
      hs = mv & out_ready;
      if (align) bits_q.delete();
      if (ser_valid) bits_q.push_back(ser_in);
      if (bits_q.size() == W) begin
        wm = 8'h00;
        wl = 8'h00;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bits_q[i];
          wl[i]     = bits_q[i];
        end
        bits_q.delete();
        if (!mv || out_ready) begin
          md_m = wm;
          md_l = wl;
          mv   = 1'b1;
        end else begin
          mov = 1'b1;
        end
      end else if (hs) begin
        mv = 1'b0;
      end
    end
  endtask

  task automatic step(input logic sv, input logic si, input logic al,
                      input logic rdy, input logic rst);
    ser_valid = sv;
    ser_in    = si;
    align     = al;
    out_ready = rdy;
    reset     = rst;
    @(posedge clk);
    model_update();
    #1;
    check("m_valid",   32'(m_valid),   32'(mv));
    check("m_data",    32'(m_data),    32'(md_m));
    check("m_count",   32'(m_count),   32'(bits_q.size()));
    check("m_overrun", 32'(m_overrun), 32'(mov));
    check("l_valid",   32'(l_valid),   32'(mv));
    check("l_data",    32'(l_data),    32'(md_l));
    check("l_count",   32'(l_count),   32'(bits_q.size()));
    check("l_overrun", 32'(l_overrun), 32'(mov));
  endtask

  // sends seq[7] first, seq[0] last, on consecutive cycles
  task automatic send_bits(input logic [7:0] seq, input logic rdy);
    for (int i = 7; i >= 0; i--) step(1'b1, seq[i], 1'b0, rdy, 1'b0);
  endtask

  initial begin
    int vcount;
    logic [7:0] seq;
    ser_in = 1'b0; ser_valid = 1'b0; align = 1'b0; out_ready = 1'b0; reset = 1'b1;
    md_m = 8'h00; md_l = 8'h00; mv = 1'b0; mov = 1'b0;

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_data",  32'(m_data),  32'h0);
    check("rst_valid", 32'(m_valid), 32'h0);
    check("rst_count", 32'(m_count), 32'h0);

    // 1/2: 1,1,0,0,0,0,0,0 -> C0 (MSB first), 03 (LSB first)
    send_bits(8'hC0, 1'b1);
    check("t1_valid", 32'(m_valid), 32'h1);
    check("t1_data",  32'(m_data),  32'hC0);
    check("t2_data",  32'(l_data),  32'h03);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_pulse", 32'(m_valid), 32'h0);

    // 3: same bits with idle gaps
    seq = 8'hC0;
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, seq[i], 1'b0, 1'b1, 1'b0);
      if (i != 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++)
          step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      end
    end
    check("t3_data", 32'(m_data), 32'hC0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 4: overrun while the consumer stalls
    send_bits(8'h3C, 1'b0);
    send_bits(8'hFF, 1'b0);
    check("t4_overrun", 32'(m_overrun), 32'h1);
    check("t4_data",    32'(m_data),    32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_valid",   32'(m_valid),   32'h0);
    check("t4_sticky",  32'(m_overrun), 32'h1);

    // 5: align without a bit, then align with a bit
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t5_count0", 32'(m_count), 32'h0);
    send_bits(8'hA5, 1'b1);
    check("t5_word", 32'(m_data), 32'hA5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t5_count1", 32'(m_count), 32'h1);
    seq = 8'h9B;
    for (int i = 6; i >= 0; i--) step(1'b1, seq[i], 1'b0, 1'b1, 1'b0);
    check("t5_word2",  32'(m_data), 32'h9B);
    check("t5_word2l", 32'(l_data), 32'hD9);

    // 6: reset mid-word, then back-to-back words
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t6_pre", 32'(m_count), 32'h4);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t6_data",    32'(m_data),    32'h0);
    check("t6_valid",   32'(m_valid),   32'h0);
    check("t6_count",   32'(m_count),   32'h0);
    check("t6_overrun", 32'(m_overrun), 32'h0);
    vcount = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
      if (m_valid) vcount++;
    end
    check("t6_words",   32'(vcount),    32'd3);
    check("t6_no_ovr",  32'(m_overrun), 32'h0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
